// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and helpers for the serial_wb_master command arbiter
package wb_arb_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  // Index width that stays at least one bit wide for single-entry sets.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set bit of req at or above start, wrapping
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;
  int           off;
  int           sum;

  always_comb begin
    // Rotating a doubled copy puts the start position at bit 0.
    rot   = N'({req, req} >> start);
    found = 1'b0;
    off   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = int'(start) + off;
    if (sum >= N) begin
      sum = sum - N;
    end
    idx = IW'(sum);
  end

endmodule

// File: rtl/wb_cmd_arbiter.sv
// rtl/wb_cmd_arbiter.sv - packet-granular round-robin arbiter in front of serial_wb_master
module wb_cmd_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int N_REQ        = 2,
  parameter  int TIMEOUT_BITS = 16,
  localparam int IW           = idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    sreset,
  input  logic [N_REQ-1:0]        req_enable,
  input  logic [N_REQ-1:0]        s_axis_cmd_tvalid,
  output logic [N_REQ-1:0]        s_axis_cmd_tready,
  input  logic [N_REQ-1:0]        s_axis_cmd_tlast,
  input  logic [BYTE_W*N_REQ-1:0] s_axis_cmd_tdata,
  output logic                    m_axis_cmd_tvalid,
  input  logic                    m_axis_cmd_tready,
  output logic                    m_axis_cmd_tlast,
  output byte_t                   m_axis_cmd_tdata,
  input  logic                    s_axis_resp_tvalid,
  output logic                    s_axis_resp_tready,
  input  byte_t                   s_axis_resp_tdata,
  output logic [N_REQ-1:0]        m_axis_resp_tvalid,
  input  logic [N_REQ-1:0]        m_axis_resp_tready,
  output byte_t                   m_axis_resp_tdata,
  output logic                    grant_valid,
  output logic [IW-1:0]           grant_idx,
  output logic                    timeout_pulse
);

  arb_state_t              state, state_d;
  logic [IW-1:0]           grant_d;
  logic [IW-1:0]           rr_ptr, rr_d;
  logic [TIMEOUT_BITS-1:0] stall_cnt, stall_d;
  logic [N_REQ-1:0]        eligible;
  logic                    pick_found;
  logic [IW-1:0]           pick_idx;
  logic                    sel_valid, sel_last;
  byte_t                   sel_data;
  logic                    hs;
  logic [IW-1:0]           next_ptr;

  assign eligible    = req_enable & s_axis_cmd_tvalid;
  assign grant_valid = (state == ARB_GRANT);
  assign next_ptr    = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (eligible),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == grant_idx) begin
        sel_valid = s_axis_cmd_tvalid[i];
        sel_last  = s_axis_cmd_tlast[i];
        sel_data  = s_axis_cmd_tdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // grant_idx doubles as the response owner: it is held after the packet ends.
  always_comb begin
    m_axis_resp_tvalid = '0;
    s_axis_resp_tready = 1'b0;
    m_axis_resp_tdata  = s_axis_resp_tdata;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == grant_idx) begin
        m_axis_resp_tvalid[i] = s_axis_resp_tvalid;
        s_axis_resp_tready    = m_axis_resp_tready[i];
      end
    end
  end

  always_comb begin
    state_d           = state;
    grant_d           = grant_idx;
    rr_d              = rr_ptr;
    stall_d           = stall_cnt;
    s_axis_cmd_tready = '0;
    m_axis_cmd_tvalid = 1'b0;
    m_axis_cmd_tlast  = 1'b0;
    m_axis_cmd_tdata  = '0;
    timeout_pulse     = 1'b0;
    hs                = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_GRANT;
          grant_d = pick_idx;
          stall_d = '0;
        end
      end
      ARB_GRANT: begin
        m_axis_cmd_tvalid = sel_valid;
        m_axis_cmd_tlast  = sel_last;
        m_axis_cmd_tdata  = sel_data;
        for (int i = 0; i < N_REQ; i++) begin
          if (IW'(i) == grant_idx) begin
            s_axis_cmd_tready[i] = m_axis_cmd_tready;
          end
        end
        hs = sel_valid & m_axis_cmd_tready;
        // A handshake outranks a terminal count in the same cycle.
        if (hs) begin
          stall_d = '0;
          if (sel_last) begin
            state_d = ARB_IDLE;
            rr_d    = next_ptr;
          end
        end else if (&stall_cnt) begin
          state_d       = ARB_IDLE;
          rr_d          = next_ptr;
          stall_d       = '0;
          timeout_pulse = 1'b1;
        end else if (!sel_valid) begin
          stall_d = stall_cnt + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_d;
      grant_idx <= grant_d;
      rr_ptr    <= rr_d;
      stall_cnt <= stall_d;
    end
  end

endmodule

// File: tb/tb_wb_cmd_arbiter.sv
// tb/tb_wb_cmd_arbiter.sv - directed scoreboard bench for wb_cmd_arbiter
module tb_wb_cmd_arbiter;

  logic       clk = 1'b0;
  logic       sreset;
  logic [1:0] req_enable;
  logic [1:0] s_cmd_tvalid, s_cmd_tready, s_cmd_tlast;
  logic [15:0] s_cmd_tdata;
  logic       m_cmd_tvalid, m_cmd_tready, m_cmd_tlast;
  logic [7:0] m_cmd_tdata;
  logic       s_resp_tvalid, s_resp_tready;
  logic [7:0] s_resp_tdata;
  logic [1:0] m_resp_tvalid, m_resp_tready;
  logic [7:0] m_resp_tdata;
  logic       grant_valid;
  logic [0:0] grant_idx;
  logic       timeout_pulse;

  always #5 clk = ~clk;

  wb_cmd_arbiter #(
    .N_REQ        (2),
    .TIMEOUT_BITS (4)
  ) dut (
    .clk                (clk),
    .sreset             (sreset),
    .req_enable         (req_enable),
    .s_axis_cmd_tvalid  (s_cmd_tvalid),
    .s_axis_cmd_tready  (s_cmd_tready),
    .s_axis_cmd_tlast   (s_cmd_tlast),
    .s_axis_cmd_tdata   (s_cmd_tdata),
    .m_axis_cmd_tvalid  (m_cmd_tvalid),
    .m_axis_cmd_tready  (m_cmd_tready),
    .m_axis_cmd_tlast   (m_cmd_tlast),
    .m_axis_cmd_tdata   (m_cmd_tdata),
    .s_axis_resp_tvalid (s_resp_tvalid),
    .s_axis_resp_tready (s_resp_tready),
    .s_axis_resp_tdata  (s_resp_tdata),
    .m_axis_resp_tvalid (m_resp_tvalid),
    .m_axis_resp_tready (m_resp_tready),
    .m_axis_resp_tdata  (m_resp_tdata),
    .grant_valid        (grant_valid),
    .grant_idx          (grant_idx),
    .timeout_pulse      (timeout_pulse)
  );

  typedef struct packed {logic last; logic [7:0] data;} beat_t;
  typedef struct packed {logic src; logic last; logic [7:0] data;} exp_t;

  beat_t txq0[$];
  beat_t txq1[$];
  exp_t  sb[$];
  exp_t  e;
  int    tests = 0;
  int    fails = 0;
  int    bad;
  logic [1:0] hs;
  logic  obs_pulse, obs_gv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int r, input logic [7:0] d, input logic l);
    beat_t b;
    b.last = l;
    b.data = d;
    if (r == 0) txq0.push_back(b);
    else        txq1.push_back(b);
  endtask

  task automatic sb_push(input int r, input logic [7:0] d, input logic l);
    exp_t x;
    x.src  = (r != 0);
    x.last = l;
    x.data = d;
    sb.push_back(x);
  endtask

  task automatic pkt3(input int r, input logic [7:0] base);
    put(r, base, 1'b0);
    put(r, base + 8'd1, 1'b0);
    put(r, base + 8'd2, 1'b1);
  endtask

  task automatic sb3(input int r, input logic [7:0] base);
    sb_push(r, base, 1'b0);
    sb_push(r, base + 8'd1, 1'b0);
    sb_push(r, base + 8'd2, 1'b1);
  endtask

  task automatic drive();
    if (txq0.size() > 0) begin
      s_cmd_tvalid[0]  = 1'b1;
      s_cmd_tlast[0]   = txq0[0].last;
      s_cmd_tdata[7:0] = txq0[0].data;
    end else begin
      s_cmd_tvalid[0]  = 1'b0;
      s_cmd_tlast[0]   = 1'b0;
      s_cmd_tdata[7:0] = 8'h00;
    end
    if (txq1.size() > 0) begin
      s_cmd_tvalid[1]   = 1'b1;
      s_cmd_tlast[1]    = txq1[0].last;
      s_cmd_tdata[15:8] = txq1[0].data;
    end else begin
      s_cmd_tvalid[1]   = 1'b0;
      s_cmd_tlast[1]    = 1'b0;
      s_cmd_tdata[15:8] = 8'h00;
    end
  endtask

  task automatic cyc();
    beat_t b;
    drive();
    @(negedge clk);
    hs        = s_cmd_tvalid & s_cmd_tready;
    obs_pulse = timeout_pulse;
    obs_gv    = grant_valid;
    @(posedge clk);
    #1;
    if (hs[0]) b = txq0.pop_front();
    if (hs[1]) b = txq1.pop_front();
    drive();
  endtask

  task automatic run_out(input string tag, input int budget);
    int n;
    n = 0;
    while ((txq0.size() > 0 || txq1.size() > 0) && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, " requester bytes drained"}, txq0.size() + txq1.size(), 0);
    chk({tag, " scoreboard empty"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    sreset = 1'b1;
    txq0.delete();
    txq1.delete();
    sb.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    sreset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!sreset && m_cmd_tvalid && m_cmd_tready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL cmd unexpected byte: observed %0h expected none", m_cmd_tdata);
      end else begin
        e = sb.pop_front();
        chk("cmd data", m_cmd_tdata, e.data);
        chk("cmd last", m_cmd_tlast, e.last);
        chk("cmd src", grant_idx, e.src);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed time limit expected finish");
    $fatal(1);
  end

  initial begin
    sreset        = 1'b1;
    req_enable    = 2'b11;
    m_cmd_tready  = 1'b1;
    s_cmd_tvalid  = '0;
    s_cmd_tlast   = '0;
    s_cmd_tdata   = '0;
    s_resp_tvalid = 1'b0;
    s_resp_tdata  = 8'h00;
    m_resp_tready = 2'b00;
    do_reset();

    chk("rst grant_valid", grant_valid, 0);
    chk("rst grant_idx", grant_idx, 0);
    chk("rst timeout_pulse", timeout_pulse, 0);
    chk("rst cmd tready", s_cmd_tready, 0);
    chk("rst m cmd tvalid", m_cmd_tvalid, 0);
    s_resp_tvalid = 1'b1;
    m_resp_tready = 2'b01;
    #1;
    chk("rst resp owner valid", m_resp_tvalid, 2'b01);
    chk("rst resp owner ready", s_resp_tready, 1);
    s_resp_tvalid = 1'b0;
    m_resp_tready = 2'b00;

    // single 4-byte packet from requester 0
    put(0, 8'h01, 1'b0); put(0, 8'h02, 1'b0); put(0, 8'h01, 1'b0); put(0, 8'h24, 1'b1);
    sb_push(0, 8'h01, 1'b0); sb_push(0, 8'h02, 1'b0); sb_push(0, 8'h01, 1'b0); sb_push(0, 8'h24, 1'b1);
    chk("t1 idle before valid", grant_valid, 0);
    cyc();
    chk("t1 no tready while idle", hs, 0);
    chk("t1 grant after 1 cycle", grant_valid, 1);
    chk("t1 grant idx", grant_idx, 0);
    run_out("t1", 10);
    chk("t1 idle after tlast", grant_valid, 0);

    // rr pointer now 1: requester 1 wins the tie
    pkt3(0, 8'h10); pkt3(1, 8'h20);
    sb3(1, 8'h20); sb3(0, 8'h10);
    run_out("t2a", 30);

    do_reset();
    pkt3(0, 8'h30); pkt3(0, 8'h40); pkt3(1, 8'h50);
    sb3(0, 8'h30); sb3(1, 8'h50); sb3(0, 8'h40);
    run_out("t2b", 40);

    // masked requester
    req_enable = 2'b01;
    pkt3(1, 8'h60);
    sb3(1, 8'h60);
    bad = 0;
    repeat (10) begin
      cyc();
      if (obs_gv) bad++;
    end
    chk("t4 masked never granted", bad, 0);
    chk("t4 masked bytes pending", txq1.size(), 3);
    req_enable = 2'b11;
    cyc();
    chk("t4 grant after enable", grant_valid, 1);
    chk("t4 grant idx after enable", grant_idx, 1);
    run_out("t4", 10);

    // stalled packet timeout
    put(1, 8'h77, 1'b0);
    sb_push(1, 8'h77, 1'b0);
    cyc();
    chk("t5 grant idx", grant_idx, 1);
    cyc();
    chk("t5 byte accepted", txq1.size(), 0);
    bad = 0;
    repeat (15) begin
      cyc();
      if (obs_pulse || !obs_gv) bad++;
    end
    chk("t5 no early timeout", bad, 0);
    cyc();
    chk("t5 timeout pulse", obs_pulse, 1);
    chk("t5 grant dropped", grant_valid, 0);
    chk("t5 grant idx retained", grant_idx, 1);
    chk("t5 pulse one cycle", timeout_pulse, 0);
    put(0, 8'h88, 1'b1);
    sb_push(0, 8'h88, 1'b1);
    cyc();
    chk("t5 req0 grantable", grant_valid, 1);
    chk("t5 req0 grant idx", grant_idx, 0);
    run_out("t5", 10);

    // long downstream backpressure is not a stall
    pkt3(0, 8'h90);
    sb3(0, 8'h90);
    cyc();
    cyc();
    m_cmd_tready = 1'b0;
    bad = 0;
    repeat (100) begin
      cyc();
      if (obs_pulse || !obs_gv) bad++;
    end
    chk("t6 no timeout under backpressure", bad, 0);
    chk("t6 bytes held", txq0.size(), 2);
    m_cmd_tready = 1'b1;
    run_out("t6", 10);

    // read response routed to requester 1 after its grant ended
    put(1, 8'hC1, 1'b0); put(1, 8'hC2, 1'b1);
    sb_push(1, 8'hC1, 1'b0); sb_push(1, 8'hC2, 1'b1);
    run_out("t7", 10);
    chk("t7 grant ended", grant_valid, 0);
    m_resp_tready = 2'b10;
    for (int b = 0; b < 3; b++) begin
      s_resp_tvalid = 1'b1;
      s_resp_tdata  = 8'hD0 + 8'(b);
      @(negedge clk);
      chk("t7 resp valid owner", m_resp_tvalid, 2'b10);
      chk("t7 resp data", m_resp_tdata, 8'hD0 + 8'(b));
      chk("t7 resp ready", s_resp_tready, 1);
      @(posedge clk);
      #1;
    end
    m_resp_tready = 2'b01;
    @(negedge clk);
    chk("t7 resp backpressure", s_resp_tready, 0);
    chk("t7 resp valid held owner", m_resp_tvalid, 2'b10);
    @(posedge clk);
    #1;
    s_resp_tvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
